// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches RV32I words over req/ack and presents them to decode over valid/ready.
// Optional macro IFU_PERF_EN adds fetch_count/stall_count performance counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [6:0]  opCode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
`ifdef IFU_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        dec_valid_q, dec_valid_d;
    logic        misalign_q, misalign_d;

    // Next-state and datapath selection; redirect overrides every other transition.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        dec_valid_d = dec_valid_q;
        misalign_d  = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d     = imem_rdata;
                    pc_d        = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + 32'd4;
                    dec_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (dec_valid_q && dec_ready) begin
                    dec_valid_d = 1'b0;
                    state_d     = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = REQ;
                end else begin
                    state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            pc_d        = pc_q;
            dec_valid_d = 1'b0;
            instr_d     = NOP_WORD;
            misalign_d  = |redirect_pc[1:0];
            if (((state_q == REQ) || (state_q == DROP)) && !imem_ack) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end else begin
            misalign_d = 1'b0;
        end
    end

    // While draining an abandoned request the old address stays on the bus.
    always_comb begin
        req_d  = (state_d == REQ) || (state_d == DROP);
        addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            instr_q     <= NOP_WORD;
            pc_q        <= RESET_PC;
            dec_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            dec_valid_q <= dec_valid_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;
    logic        stall_s;

    // A stall is a cycle waiting on memory or on decode.
    always_comb begin
        stall_s = (((state_q == REQ) || (state_q == DROP)) && !imem_ack) ||
                  ((state_q == HOLD) && !dec_ready);
    end

    // Performance counters, free-running with natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            if (dec_valid_q && dec_ready) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (stall_s) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign dec_valid = dec_valid_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign misalign  = misalign_q;
    assign opCode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a behavioural instruction memory of programmable ack latency.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        misalign;

    int tests_run;
    int tests_failed;
    int ack_delay;
    int wait_cnt;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .instr       (instr),
        .pc          (pc),
        .opCode      (opCode),
        .funct3      (funct3),
        .funct7      (funct7),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0008: mem_word = 32'h40B5_0533;
            default:       mem_word = 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);

    // Counts cycles the current request has waited without ack.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        ack_delay = 0; wait_cnt = 0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b1;
        tick(); tick();
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, 32'd0);
        check_eq("rst_valid", {31'd0, dec_valid}, 32'd0);
        check_eq("rst_instr", instr, NOP);
        check_eq("rst_pc",    pc, 32'd0);
        check_eq("rst_mis",   {31'd0, misalign}, 32'd0);

        // Zero-wait fetch from address 0
        rst = 1'b0;
        tick();
        check_eq("c1_req",  {31'd0, imem_req}, 32'd1);
        check_eq("c1_addr", imem_addr, 32'd0);
        tick();
        check_eq("c2_valid",  {31'd0, dec_valid}, 32'd1);
        check_eq("c2_pc",     pc, 32'd0);
        check_eq("c2_instr",  instr, 32'h0050_0093);
        check_eq("c2_opcode", {25'd0, opCode}, 32'h13);
        check_eq("c2_funct3", {29'd0, funct3}, 32'd0);
        check_eq("c2_funct7", {25'd0, funct7}, 32'd0);
        check_eq("c2_addr",   imem_addr, 32'd4);
        check_eq("c2_req",    {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("f4_addr", imem_addr, 32'd4);
        tick();
        check_eq("f4_pc",    pc, 32'd4);
        check_eq("f4_instr", instr, 32'hC0DE_0004);

        // Ack delayed 3 cycles at 0x8, decode stalls afterwards
        ack_delay = 3;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("d3_req",  {31'd0, imem_req}, 32'd1);
            check_eq("d3_addr", imem_addr, 32'd8);
            check_eq("d3_valid", {31'd0, dec_valid}, 32'd0);
            if (i < 3) tick();
        end
        ack_delay = 0;
        tick();
        check_eq("d3_instr",  instr, 32'h40B5_0533);
        check_eq("d3_funct7", {25'd0, funct7}, 32'h20);
        check_eq("d3_funct3", {29'd0, funct3}, 32'd0);
        check_eq("d3_opcode", {25'd0, opCode}, 32'h33);
        check_eq("d3_pc",     pc, 32'd8);

        for (int i = 0; i < 5; i++) begin
            check_eq("st_instr", instr, 32'h40B5_0533);
            check_eq("st_pc",    pc, 32'd8);
            check_eq("st_req",   {31'd0, imem_req}, 32'd0);
            check_eq("st_valid", {31'd0, dec_valid}, 32'd1);
            tick();
        end
        dec_ready = 1'b1;
        tick();
        check_eq("st_next_req",  {31'd0, imem_req}, 32'd1);
        check_eq("st_next_addr", imem_addr, 32'h0000_000C);
        tick();
        check_eq("fc_pc", pc, 32'h0000_000C);

        // Redirect while fetch at 0x10 is outstanding
        ack_delay = 1000;
        tick();
        check_eq("dr_addr0", imem_addr, 32'h10);
        check_eq("dr_ack0",  {31'd0, imem_ack}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check_eq("dr_req",   {31'd0, imem_req}, 32'd1);
        check_eq("dr_addr",  imem_addr, 32'h10);
        check_eq("dr_valid", {31'd0, dec_valid}, 32'd0);
        check_eq("dr_instr", instr, NOP);
        check_eq("dr_mis",   {31'd0, misalign}, 32'd0);
        tick();
        check_eq("dr_addr2", imem_addr, 32'h10);
        ack_delay = 0;
        tick();
        check_eq("dr_new_addr",  imem_addr, 32'h100);
        check_eq("dr_new_req",   {31'd0, imem_req}, 32'd1);
        check_eq("dr_new_valid", {31'd0, dec_valid}, 32'd0);
        check_eq("dr_new_instr", instr, NOP);
        tick();
        check_eq("dr_word_valid", {31'd0, dec_valid}, 32'd1);
        check_eq("dr_word_pc",    pc, 32'h100);
        check_eq("dr_word_instr", instr, 32'hC0DE_0100);

        // Misaligned redirect coinciding with a decode handshake
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        check_eq("ma_pulse", {31'd0, misalign}, 32'd1);
        check_eq("ma_addr",  imem_addr, 32'h200);
        check_eq("ma_valid", {31'd0, dec_valid}, 32'd0);
        tick();
        check_eq("ma_clear", {31'd0, misalign}, 32'd0);
        check_eq("ma_pc",    pc, 32'h200);

        // Fetch PC wrap at the top of the address space
        dec_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check_eq("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wr_pc",   pc, 32'hFFFF_FFFC);
        check_eq("wr_next", imem_addr, 32'h0000_0000);
        dec_ready = 1'b1;
        ack_delay = 1000;
        tick();
        check_eq("wr_req",   {31'd0, imem_req}, 32'd1);
        check_eq("wr_addr0", imem_addr, 32'h0000_0000);

        // Reset in the middle of an outstanding request
        rst = 1'b1;
        tick();
        check_eq("mr_req",   {31'd0, imem_req}, 32'd0);
        check_eq("mr_pc",    pc, 32'd0);
        check_eq("mr_valid", {31'd0, dec_valid}, 32'd0);
        check_eq("mr_instr", instr, NOP);
        check_eq("mr_addr",  imem_addr, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("mr_restart", {31'd0, imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Producer side of the control unit's instruction interface. Fetches 32-bit RV32I words from instruction memory over a req/ack handshake and holds each word in an output register. Presents the opCode/funct3/funct7 fields plus the full word and its PC to the decode/control stage over a valid/ready handshake. Accepts PC redirects from the branch/jump path (BrOp resolution).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_WORD, 32'h0000_0013, instr value driven at reset and after a flush (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory response valid; sampled only while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
redirect  in  1  one-cycle pulse: replace fetch PC
redirect_pc  in  32  new PC, valid with redirect
dec_valid  out  1  instr/pc/fields valid for decode
dec_ready  in  1  decode accepts current instruction
instr  out  32  fetched instruction word
pc  out  32  address of instr
opCode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]
misalign  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero

Behaviour:
- Reset (synchronous, also mid-operation): state IDLE, fetch PC = RESET_PC, imem_req=0, imem_addr=RESET_PC, dec_valid=0, instr=NOP_WORD, pc=RESET_PC, misalign=0. An outstanding memory request is abandoned; memory tolerates this.
- opCode, funct3 and funct7 are combinational slices of the instr register.
- States: IDLE, REQ, HOLD, DROP.
- IDLE -> REQ unconditionally on the next cycle.
- REQ: imem_req=1, imem_addr=fetch PC. req and addr are held stable until ack. On ack: instr<=imem_rdata, pc<=fetch PC, fetch PC<=fetch PC+4 (32-bit wrap, 0xFFFFFFFC->0), dec_valid<=1, go to HOLD. A same-cycle ack (combinational memory) is legal: req in cycle N, ack in N, dec_valid in N+1.
- HOLD: imem_req=0. instr, pc and fields stay stable while dec_valid & !dec_ready. On dec_valid & dec_ready: dec_valid<=0, go to REQ. Throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect has top priority over all other transitions:
  - Fetch PC <= {redirect_pc[31:2],2'b00}. dec_valid<=0. instr<=NOP_WORD.
  - misalign<=|redirect_pc[1:0] for one cycle.
  - From IDLE or HOLD: go to REQ.
  - From REQ with imem_ack=1 in the same cycle: rdata is discarded; go to REQ at the new PC.
  - From REQ with imem_ack=0: go to DROP. imem_req and the old imem_addr stay held until ack.
  - DROP: on ack, discard rdata and go to REQ with the new PC. A redirect while in DROP updates the pending PC and keeps the state DROP.
- A redirect in HOLD in the same cycle as a dec_ready handshake: the handshake completes (decode consumed the word), then the redirect applies.

Optional Feature:
IFU_PERF_EN.
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0].
  - fetch_count increments on each accepted dec_valid&dec_ready.
  - stall_count increments each cycle in REQ/DROP with imem_ack=0, or in HOLD with dec_ready=0.
  - Both are 0 on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, zero-wait memory returning 0x00500093 at address 0, dec_ready=1 -> first dec_valid at cycle 2 after rst release; pc=0, opCode=0x13, funct3=0, funct7=0; next imem_addr=4.
- Memory ack delayed 3 cycles for word 0x40B50533 at 0x8 -> imem_req/imem_addr=0x8 held 4 cycles; then instr=0x40B50533, funct7=0x20, funct3=0, opCode=0x33.
- dec_ready=0 for 5 cycles in HOLD -> instr/pc unchanged, imem_req=0 throughout; fetch at pc+4 starts the cycle after dec_ready=1.
- redirect to 0x100 while REQ at 0x10 is outstanding without ack -> DROP; the late ack's rdata is never presented; next imem_addr=0x100; dec_valid=0 until the 0x100 word arrives.
- redirect_pc=0x203 -> misalign pulse of 1 cycle; imem_addr=0x200.
- Fetch PC 0xFFFFFFFC accepted -> next imem_addr=0x00000000; rst asserted during REQ -> next cycle IDLE, imem_req=0, pc=RESET_PC.
